// File: rtl/spi_master_if.sv
// Byte-stream and SPI pin bundle for spi_master.
//   master modport: the spi_master side (drives tx_ready, rx_*, busy, SCK, SSEL, MOSI;
//                   receives tx_data, tx_last, tx_valid, MISO).
//   slave modport : the user / peripheral side, directions mirrored.
`timescale 1ns/1ps

interface spi_master_if;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       SCK;
    logic       SSEL;
    logic       MOSI;
    logic       MISO;

    modport master (
        input  tx_data, tx_last, tx_valid, MISO,
        output tx_ready, rx_data, rx_valid, busy, SCK, SSEL, MOSI
    );

    modport slave (
        output tx_data, tx_last, tx_valid, MISO,
        input  tx_ready, rx_data, rx_valid, busy, SCK, SSEL, MOSI
    );
endinterface

// File: rtl/spi_master.sv
// SPI master, mode 0 (SCK idle low, data changes on SCK fall, sampled on rise side),
// MSB first, one byte per accepted tx beat. SSEL stays low between bytes until a byte
// tagged tx_last completes.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - spi_master_if.master: tx_data/tx_last/tx_valid/tx_ready byte input,
//          rx_data/rx_valid received byte, busy, SCK/SSEL/MOSI/MISO pins
// Parameter CLK_DIV: clk cycles per SCK half-period (4..256).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | SSEL high, waiting for the first byte of a frame
// SETUP | SSEL low, MOSI holds bit 7, SCK low for one half-period
// HIGH  | SCK high; MISO sampled on the last cycle
// LOW   | SCK low; MOSI holds the next bit
// WAIT  | byte done, frame still open, waiting for the next byte
// END   | SSEL high for one half-period before returning to IDLE
`timescale 1ns/1ps

module spi_master #(
    parameter int CLK_DIV = 8
) (
    input  logic          clk,
    input  logic          rst,
    spi_master_if.master  bus
);

    localparam int            CW       = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_WAIT,
        S_END
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [6:0]    tx_shift_q;   // bits still to send after the one on MOSI
    logic [6:0]    rx_shift_q;   // first seven received bits
    logic          last_q;
    logic          sck_q, ssel_q, mosi_q, rx_valid_q;
    logic [7:0]    rx_data_q;

    logic          sck_d, ssel_d, mosi_d, rx_valid_d;
    logic          tx_ready_w, accept, cnt_done, bit_done, cnt_run, high_end;

    assign tx_ready_w = (state_q == S_IDLE) || (state_q == S_WAIT);
    assign accept     = bus.tx_valid && tx_ready_w;
    assign cnt_done   = (cnt_q == CNT_LAST);
    assign bit_done   = (bit_q == 3'd7);
    assign high_end   = (state_q == S_HIGH) && cnt_done;
    assign cnt_run    = (state_q == S_SETUP) || (state_q == S_HIGH) ||
                        (state_q == S_LOW)   || (state_q == S_END);

    // State register plus all registered outputs and datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            last_q     <= 1'b0;
            sck_q      <= 1'b0;
            ssel_q     <= 1'b1;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            sck_q      <= sck_d;
            ssel_q     <= ssel_d;
            mosi_q     <= mosi_d;
            rx_valid_q <= rx_valid_d;

            // Half-period counter restarts on every state change; it only
            // runs in the timed states.
            if (state_d != state_q)
                cnt_q <= '0;
            else if (cnt_run)
                cnt_q <= cnt_q + CNT_ONE;

            if (accept) begin
                tx_shift_q <= bus.tx_data[6:0];
                last_q     <= bus.tx_last;
                bit_q      <= '0;
            end else if (high_end && !bit_done) begin
                tx_shift_q <= {tx_shift_q[5:0], 1'b0};
                bit_q      <= bit_q + 3'd1;
            end

            if (high_end)
                rx_shift_q <= {rx_shift_q[5:0], bus.MISO};
            if (rx_valid_d)
                rx_data_q <= {rx_shift_q, bus.MISO};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:         if (accept)   state_d = S_SETUP;
            S_SETUP, S_LOW: if (cnt_done) state_d = S_HIGH;
            S_HIGH: begin
                if (cnt_done) begin
                    if (!bit_done)   state_d = S_LOW;
                    else if (last_q) state_d = S_END;
                    else             state_d = S_WAIT;
                end
            end
            S_WAIT:         if (accept)   state_d = S_LOW;
            S_END:          if (cnt_done) state_d = S_IDLE;
            default:                      state_d = S_IDLE;
        endcase
    end

    // Next values for the registered pins are decoded from the next state so
    // SCK/SSEL switch on the same edge as the state itself.
    always_comb begin
        sck_d      = (state_d == S_HIGH);
        ssel_d     = (state_d == S_IDLE) || (state_d == S_END);
        rx_valid_d = high_end && bit_done;
        mosi_d     = mosi_q;
        if (accept)
            mosi_d = bus.tx_data[7];
        else if (high_end)
            // MOSI parks at 0 when the byte ends so IDLE needs no extra edge.
            mosi_d = bit_done ? 1'b0 : tx_shift_q[6];
    end

    assign bus.tx_ready = tx_ready_w;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.SCK      = sck_q;
    assign bus.SSEL     = ssel_q;
    assign bus.MOSI     = mosi_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a CLK_DIV=4 instance for the protocol scenarios and a
// CLK_DIV=256 instance for long half-periods and END-phase handshake behaviour.
`timescale 1ns/1ps

module tb_spi_master;

    logic clk = 1'b0;
    logic rst4, rst256;
    always #5 clk = ~clk;

    spi_master_if if4 ();
    spi_master_if if256 ();

    spi_master #(.CLK_DIV(4))   u_dut4   (.clk(clk), .rst(rst4),   .bus(if4.master));
    spi_master #(.CLK_DIV(256)) u_dut256 (.clk(clk), .rst(rst256), .bus(if256.master));

    int n_checks = 0;
    int n_pass   = 0;

    // MISO: loopback, or a slave model shifting out miso_pat
    logic       miso_mode = 1'b0;
    logic       miso_bit  = 1'b0;
    logic [7:0] miso_pat  = 8'h00;
    int         miso_idx  = 0;
    int         miso_cd   = 0;
    logic       pm_ssel   = 1'b1;
    logic       pm_sck    = 1'b0;

    always_comb if4.MISO   = miso_mode ? miso_bit : if4.MOSI;
    always_comb if256.MISO = if256.MOSI;

    always @(negedge clk) begin
        if (miso_mode) begin
            if (!if4.SSEL && pm_ssel) begin
                miso_bit = miso_pat[7];
                miso_idx = 6;
                miso_cd  = 0;
            end else if (!if4.SCK && pm_sck) begin
                miso_cd = 3;
            end else if (miso_cd > 0) begin
                miso_cd--;
                if (miso_cd == 0 && miso_idx >= 0) begin
                    miso_bit = miso_pat[miso_idx];
                    miso_idx--;
                end
            end
        end
        pm_ssel = if4.SSEL;
        pm_sck  = if4.SCK;
    end

    // Monitor for the CLK_DIV=4 instance
    int         cyc4 = 0, m4_rises = 0, m4_rxv = 0, m4_ssel_low = 0, m4_end_cyc = 0;
    int         m4_viol = 0, m4_gap_max = 0, m4_last_fall = 0;
    bit         m4_fall_seen = 1'b0;
    logic [7:0] m4_mosi_log = 8'h00;
    logic [7:0] rx_q4[$];
    logic       p4_sck = 1'b0, p4_mosi = 1'b0;

    always @(negedge clk) begin
        cyc4++;
        if (if4.SCK && !p4_sck) begin
            m4_rises++;
            m4_mosi_log = {m4_mosi_log[6:0], if4.MOSI};
            if (m4_fall_seen && (cyc4 - m4_last_fall) > m4_gap_max)
                m4_gap_max = cyc4 - m4_last_fall;
        end
        if (!if4.SCK && p4_sck) begin
            m4_last_fall = cyc4;
            m4_fall_seen = 1'b1;
        end
        if ((if4.MOSI !== p4_mosi) && if4.SCK) m4_viol++;
        if (if4.SSEL === 1'b0) m4_ssel_low++;
        if (if4.busy && if4.SSEL) m4_end_cyc++;
        if (if4.rx_valid) begin
            m4_rxv++;
            rx_q4.push_back(if4.rx_data);
        end
        p4_sck  = if4.SCK;
        p4_mosi = if4.MOSI;
    end

    // Monitor for the CLK_DIV=256 instance
    int         m2_rises = 0, m2_rxv = 0, m2_end_cyc = 0, m2_hi_run = 0, cyc2 = 0;
    int         m2_hi_min = 100000, m2_hi_max = 0, m2_lo_min = 100000, m2_lo_max = 0;
    int         m2_last_fall = 0;
    bit         m2_fall_seen = 1'b0;
    logic [7:0] m2_rx = 8'h00;
    logic       p2_sck = 1'b0;

    always @(negedge clk) begin
        int g;
        cyc2++;
        if (if256.SCK === 1'b1) m2_hi_run++;
        if (if256.SCK && !p2_sck) begin
            m2_rises++;
            if (m2_fall_seen) begin
                g = cyc2 - m2_last_fall;
                if (g < m2_lo_min) m2_lo_min = g;
                if (g > m2_lo_max) m2_lo_max = g;
            end
        end
        if (!if256.SCK && p2_sck) begin
            if (m2_hi_run < m2_hi_min) m2_hi_min = m2_hi_run;
            if (m2_hi_run > m2_hi_max) m2_hi_max = m2_hi_run;
            m2_hi_run    = 0;
            m2_last_fall = cyc2;
            m2_fall_seen = 1'b1;
        end
        if (if256.busy && if256.SSEL) m2_end_cyc++;
        if (if256.rx_valid) begin
            m2_rxv++;
            m2_rx = if256.rx_data;
        end
        p2_sck = if256.SCK;
    end

    task automatic clr4();
        @(posedge clk);
        #1;
        m4_rises = 0; m4_rxv = 0; m4_ssel_low = 0; m4_end_cyc = 0;
        m4_viol = 0; m4_gap_max = 0; m4_fall_seen = 1'b0; m4_mosi_log = 8'h00;
        rx_q4.delete();
    endtask

    task automatic send4(input logic [7:0] d, input logic l);
        int t = 0;
        @(negedge clk);
        if4.tx_data = d; if4.tx_last = l; if4.tx_valid = 1'b1;
        while (!if4.tx_ready && t < 2000) begin @(negedge clk); t++; end
        if (!if4.tx_ready) begin
            n_checks++;
            $display("FAIL send4_timeout: tx_ready=%b required 1", if4.tx_ready);
        end
        @(posedge clk);
        #1 if4.tx_valid = 1'b0;
    endtask

    task automatic wait_idle4(input int budget);
        int t = 0;
        @(negedge clk);
        while (if4.busy && t < budget) begin @(negedge clk); t++; end
        if (if4.busy) begin
            n_checks++;
            $display("FAIL wait_idle4_timeout: busy=%b required 0", if4.busy);
        end
    endtask

    task automatic test_reset();
        rst4 = 1'b1; rst256 = 1'b1;
        if4.tx_valid = 1'b0; if4.tx_data = 8'h00; if4.tx_last = 1'b0;
        if256.tx_valid = 1'b0; if256.tx_data = 8'h00; if256.tx_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (if4.SSEL !== 1'b1) $display("FAIL reset_ssel: got %b want 1", if4.SSEL); else n_pass++;
        n_checks++; if (if4.SCK !== 1'b0) $display("FAIL reset_sck: got %b want 0", if4.SCK); else n_pass++;
        n_checks++; if (if4.MOSI !== 1'b0) $display("FAIL reset_mosi: got %b want 0", if4.MOSI); else n_pass++;
        n_checks++; if (if4.rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b want 0", if4.rx_valid); else n_pass++;
        n_checks++; if (if4.rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", if4.rx_data); else n_pass++;
        n_checks++; if (if4.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", if4.busy); else n_pass++;
        n_checks++; if (if256.SSEL !== 1'b1) $display("FAIL reset_ssel_256: got %b want 1", if256.SSEL); else n_pass++;
        rst4 = 1'b0; rst256 = 1'b0;
        @(negedge clk);
        n_checks++; if (if4.tx_ready !== 1'b1) $display("FAIL reset_tx_ready: got %b want 1", if4.tx_ready); else n_pass++;
        n_checks++; if (if256.tx_ready !== 1'b1) $display("FAIL reset_tx_ready_256: got %b want 1", if256.tx_ready); else n_pass++;
    endtask

    task automatic test_loopback();
        clr4();
        miso_mode = 1'b0;
        send4(8'hA5, 1'b1);
        wait_idle4(500);
        n_checks++; if (m4_rises != 8) $display("FAIL loop_sck_rises: got %0d want 8", m4_rises); else n_pass++;
        n_checks++; if (m4_mosi_log !== 8'hA5) $display("FAIL loop_mosi_seq: got %h want a5", m4_mosi_log); else n_pass++;
        n_checks++; if (if4.rx_data !== 8'hA5) $display("FAIL loop_rx_data: got %h want a5", if4.rx_data); else n_pass++;
        n_checks++; if (m4_rxv != 1) $display("FAIL loop_rx_pulses: got %0d want 1", m4_rxv); else n_pass++;
        n_checks++; if (m4_ssel_low != 64) $display("FAIL loop_ssel_low: got %0d want 64", m4_ssel_low); else n_pass++;
        n_checks++; if (m4_end_cyc != 4) $display("FAIL loop_end_cycles: got %0d want 4", m4_end_cyc); else n_pass++;
        n_checks++; if (m4_gap_max != 4) $display("FAIL loop_low_phase: got %0d want 4", m4_gap_max); else n_pass++;
        n_checks++; if (m4_viol != 0) $display("FAIL loop_mosi_stable: got %0d changes while SCK high want 0", m4_viol); else n_pass++;
        n_checks++; if (if4.MOSI !== 1'b0) $display("FAIL loop_idle_mosi: got %b want 0", if4.MOSI); else n_pass++;
    endtask

    task automatic test_miso_model();
        clr4();
        miso_pat  = 8'h3C;
        miso_mode = 1'b1;
        send4(8'h00, 1'b1);
        wait_idle4(500);
        n_checks++; if (if4.rx_data !== 8'h3C) $display("FAIL miso_rx_data: got %h want 3c", if4.rx_data); else n_pass++;
        n_checks++; if (m4_rxv != 1) $display("FAIL miso_rx_pulses: got %0d want 1", m4_rxv); else n_pass++;
        n_checks++; if (m4_mosi_log !== 8'h00) $display("FAIL miso_mosi_seq: got %h want 00", m4_mosi_log); else n_pass++;
        miso_mode = 1'b0;
    endtask

    task automatic test_wait();
        int t = 0;
        int errs = 0;
        logic [7:0] r0, r1;
        clr4();
        send4(8'h12, 1'b0);
        while (!if4.rx_valid && t < 200) begin @(negedge clk); t++; end
        n_checks++; if (if4.rx_valid !== 1'b1) $display("FAIL wait_rx1_timeout: rx_valid=%b want 1", if4.rx_valid); else n_pass++;
        repeat (20) begin
            @(negedge clk);
            if (if4.SSEL !== 1'b0 || if4.SCK !== 1'b0 || if4.tx_ready !== 1'b1) errs++;
        end
        n_checks++; if (errs != 0) $display("FAIL wait_hold: got %0d bad cycles want 0", errs); else n_pass++;
        send4(8'h34, 1'b1);
        wait_idle4(500);
        r0 = (rx_q4.size() > 0) ? rx_q4[0] : 8'hxx;
        r1 = (rx_q4.size() > 1) ? rx_q4[1] : 8'hxx;
        n_checks++; if (r0 !== 8'h12) $display("FAIL wait_rx0: got %h want 12", r0); else n_pass++;
        n_checks++; if (r1 !== 8'h34) $display("FAIL wait_rx1: got %h want 34", r1); else n_pass++;
        n_checks++; if (m4_rxv != 2) $display("FAIL wait_rx_pulses: got %0d want 2", m4_rxv); else n_pass++;
        n_checks++; if (m4_rises != 16) $display("FAIL wait_sck_rises: got %0d want 16", m4_rises); else n_pass++;
        n_checks++; if (m4_end_cyc != 4) $display("FAIL wait_ssel_high_cycles: got %0d want 4", m4_end_cyc); else n_pass++;
        n_checks++; if (m4_viol != 0) $display("FAIL wait_mosi_stable: got %0d want 0", m4_viol); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int t = 0;
        logic [7:0] r0, r1;
        clr4();
        @(negedge clk);
        if4.tx_data = 8'hFF; if4.tx_last = 1'b0; if4.tx_valid = 1'b1;
        @(posedge clk);
        #1 if4.tx_data = 8'h00; if4.tx_last = 1'b1;
        @(negedge clk);
        while (!if4.tx_ready && t < 200) begin @(negedge clk); t++; end
        n_checks++; if (if4.tx_ready !== 1'b1) $display("FAIL b2b_ready_timeout: got %b want 1", if4.tx_ready); else n_pass++;
        n_checks++; if (if4.rx_valid !== 1'b1) $display("FAIL b2b_ready_with_rx_valid: got %b want 1", if4.rx_valid); else n_pass++;
        @(posedge clk);
        #1 if4.tx_valid = 1'b0;
        wait_idle4(500);
        r0 = (rx_q4.size() > 0) ? rx_q4[0] : 8'hxx;
        r1 = (rx_q4.size() > 1) ? rx_q4[1] : 8'hxx;
        n_checks++; if (r0 !== 8'hFF) $display("FAIL b2b_rx0: got %h want ff", r0); else n_pass++;
        n_checks++; if (r1 !== 8'h00) $display("FAIL b2b_rx1: got %h want 00", r1); else n_pass++;
        n_checks++; if (m4_rises != 16) $display("FAIL b2b_sck_rises: got %0d want 16", m4_rises); else n_pass++;
        n_checks++; if (m4_gap_max != 5) $display("FAIL b2b_max_low_gap: got %0d want 5", m4_gap_max); else n_pass++;
        n_checks++; if (m4_ssel_low != 129) $display("FAIL b2b_ssel_low: got %0d want 129", m4_ssel_low); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int t = 0;
        clr4();
        send4(8'h81, 1'b1);
        while (m4_rises < 3 && t < 200) begin @(negedge clk); t++; end
        n_checks++; if (m4_rises != 3) $display("FAIL rstmid_rises_before: got %0d want 3", m4_rises); else n_pass++;
        rst4 = 1'b1;
        @(negedge clk);
        n_checks++; if (if4.SSEL !== 1'b1) $display("FAIL rstmid_ssel: got %b want 1", if4.SSEL); else n_pass++;
        n_checks++; if (if4.SCK !== 1'b0) $display("FAIL rstmid_sck: got %b want 0", if4.SCK); else n_pass++;
        n_checks++; if (if4.rx_data !== 8'h00) $display("FAIL rstmid_rx_data: got %h want 00", if4.rx_data); else n_pass++;
        rst4 = 1'b0;
        @(negedge clk);
        n_checks++; if (if4.tx_ready !== 1'b1) $display("FAIL rstmid_tx_ready: got %b want 1", if4.tx_ready); else n_pass++;
        n_checks++; if (m4_rxv != 0) $display("FAIL rstmid_no_rx_valid: got %0d want 0", m4_rxv); else n_pass++;
        clr4();
        send4(8'h81, 1'b1);
        wait_idle4(500);
        n_checks++; if (if4.rx_data !== 8'h81) $display("FAIL rstmid_fresh_rx: got %h want 81", if4.rx_data); else n_pass++;
        n_checks++; if (m4_rises != 8) $display("FAIL rstmid_fresh_rises: got %0d want 8", m4_rises); else n_pass++;
        n_checks++; if (m4_mosi_log !== 8'h81) $display("FAIL rstmid_fresh_mosi: got %h want 81", m4_mosi_log); else n_pass++;
        n_checks++; if (m4_rxv != 1) $display("FAIL rstmid_fresh_pulses: got %0d want 1", m4_rxv); else n_pass++;
    endtask

    task automatic test_div256();
        int t = 0;
        int errs = 0;
        @(negedge clk);
        if256.tx_data = 8'h5A; if256.tx_last = 1'b1; if256.tx_valid = 1'b1;
        @(posedge clk);
        #1 if256.tx_valid = 1'b0;
        @(negedge clk);
        while (!(if256.busy && if256.SSEL) && t < 6000) begin @(negedge clk); t++; end
        n_checks++; if (!(if256.busy && if256.SSEL)) $display("FAIL div256_end_timeout: busy=%b ssel=%b want 1 1", if256.busy, if256.SSEL); else n_pass++;
        n_checks++; if (if256.tx_ready !== 1'b0) $display("FAIL div256_end_ready: got %b want 0", if256.tx_ready); else n_pass++;
        repeat (10) @(negedge clk);
        if256.tx_data = 8'hC3; if256.tx_last = 1'b0; if256.tx_valid = 1'b1;
        @(negedge clk);
        if256.tx_valid = 1'b0;
        t = 0;
        while (if256.busy && t < 600) begin @(negedge clk); t++; end
        repeat (20) begin
            @(negedge clk);
            if (if256.busy !== 1'b0 || if256.SSEL !== 1'b1) errs++;
        end
        n_checks++; if (errs != 0) $display("FAIL div256_end_pulse_ignored: got %0d busy cycles want 0", errs); else n_pass++;
        n_checks++; if (m2_rises != 8) $display("FAIL div256_rises: got %0d want 8", m2_rises); else n_pass++;
        n_checks++; if (m2_hi_min != 256 || m2_hi_max != 256) $display("FAIL div256_high: got %0d..%0d want 256", m2_hi_min, m2_hi_max); else n_pass++;
        n_checks++; if (m2_lo_min != 256 || m2_lo_max != 256) $display("FAIL div256_low: got %0d..%0d want 256", m2_lo_min, m2_lo_max); else n_pass++;
        n_checks++; if (m2_end_cyc != 256) $display("FAIL div256_end_cycles: got %0d want 256", m2_end_cyc); else n_pass++;
        n_checks++; if (m2_rxv != 1) $display("FAIL div256_rx_pulses: got %0d want 1", m2_rxv); else n_pass++;
        n_checks++; if (m2_rx !== 8'h5A) $display("FAIL div256_rx_data: got %h want 5a", m2_rx); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_miso_model();
        test_wait();
        test_back_to_back();
        test_reset_mid();
        test_div256();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
